// File: rtl/dff_en_led_pkg.sv
// Shared constants for the dff_en_led key/LED demo: default sizes, enable
// bit position and the all-zeros reset level used by every register.
package dff_en_led_pkg;

  localparam int WIDTH_DEFAULT       = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Enable/flag bit position for the default width.
  localparam int EN_BIT_DEFAULT = WIDTH_DEFAULT - 1;

  localparam logic RESET_BIT = 1'b0;
  localparam logic [WIDTH_DEFAULT-1:0] RESET_VALUE_DEFAULT = {WIDTH_DEFAULT{RESET_BIT}};

  // Top key of any width acts as the load enable.
  function automatic int en_index(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/dff_en_led_key_sync.sv
// key_sync: per-bit multi-flop synchronizer with synchronous active-high
// reset; every stage clears to zero so the pipeline refills from a known state.
module key_sync
  import dff_en_led_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= {WIDTH{RESET_BIT}};
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/dff_en_led.sv
// dff_en_led: 4-key/4-LED clock-enable register demo. Define
// DFF_EN_LED_KEY_SYNC_EN to pass the keys through the key_sync chain first.
module dff_en_led
  import dff_en_led_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk50m_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] key_i,
  output logic [WIDTH-1:0] led_o
);

  localparam int EN_IDX = en_index(WIDTH);

  // Elaboration-time guard on the parameter minimums.
  if (WIDTH < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("dff_en_led: WIDTH and SYNC_STAGES must both be at least 2");
  end

  logic [WIDTH-1:0] key_cond;
  logic             en;
  logic [WIDTH-2:0] d;
  logic [WIDTH-2:0] q;
  logic             loaded;

`ifdef DFF_EN_LED_KEY_SYNC_EN
  key_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_key_sync (
    .clk  (clk50m_i),
    .rst  (rst_i),
    .din  (key_i),
    .dout (key_cond)
  );
`else
  assign key_cond = key_i;
`endif

  assign en = key_cond[EN_IDX];
  assign d  = key_cond[EN_IDX-1:0];

  // Enable gates the load; reset wins over enable and masks any X on the keys.
  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      q      <= {(WIDTH-1){RESET_BIT}};
      loaded <= RESET_BIT;
    end else if (en) begin
      q      <= d;
      loaded <= 1'b1;
    end
  end

  assign led_o = {loaded, q};

endmodule

// File: tb/tb_dff_en_led.sv
// Directed self-checking bench for dff_en_led; adapts its expected latency
// to whether DFF_EN_LED_KEY_SYNC_EN is defined.
module tb_dff_en_led;

  localparam int WIDTH       = 4;
  localparam int SYNC_STAGES = 2;
`ifdef DFF_EN_LED_KEY_SYNC_EN
  localparam int LAT = SYNC_STAGES + 1;
`else
  localparam int LAT = 1;
`endif

  logic             clk50m_i;
  logic             rst_i;
  logic [WIDTH-1:0] key_i;
  logic [WIDTH-1:0] led_o;

  int test_count = 0;
  int fail_count = 0;

  dff_en_led #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk50m_i (clk50m_i),
    .rst_i    (rst_i),
    .key_i    (key_i),
    .led_o    (led_o)
  );

  initial clk50m_i = 1'b0;
  always #10 clk50m_i = ~clk50m_i;

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] key, input logic rst);
    @(negedge clk50m_i);
    key_i = key;
    rst_i = rst;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk50m_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: led_o=%h expected %h", tag, observed, expected);
    end
  endtask

  logic [WIDTH-1:0] stuck_vec [6];

  initial begin
    key_i = '0;
    rst_i = 1'b0;
    stuck_vec[0] = 4'hF; stuck_vec[1] = 4'hC; stuck_vec[2] = 4'h9;
    stuck_vec[3] = 4'hE; stuck_vec[4] = 4'h8; stuck_vec[5] = 4'hB;

    // Reset with all keys pressed, then release reset.
    applyStimulus(4'hF, 1'b1);
    waitEdges(1);
    checkOutput("reset", led_o, 4'h0);
    applyStimulus(4'hF, 1'b0);
    waitEdges(LAT);
    checkOutput("post_reset_load", led_o, 4'hF);

    // Enable load sweep.
    for (int k = 15; k >= 8; k--) begin
      applyStimulus(WIDTH'(k), 1'b0);
      waitEdges(LAT);
      checkOutput("load_sweep", led_o, WIDTH'(k));
    end

    // Hold while enable is low.
    for (int k = 7; k >= 1; k--) begin
      applyStimulus(WIDTH'(k), 1'b0);
      waitEdges(LAT);
      checkOutput("hold", led_o, 4'h8);
    end

    // Reset mid-operation; flag must stay clear afterwards with en=0.
    applyStimulus(4'hD, 1'b0);
    waitEdges(LAT);
    checkOutput("mid_load", led_o, 4'hD);
    applyStimulus(4'h5, 1'b1);
    waitEdges(1);
    checkOutput("mid_reset", led_o, 4'h0);
    applyStimulus(4'h5, 1'b0);
    waitEdges(LAT + 2);
    checkOutput("mid_reset_stays", led_o, 4'h0);

    // Simultaneous en/d change from reset state: no load of d=1.
    applyStimulus(4'h0, 1'b1);
    waitEdges(1);
    applyStimulus(4'h1, 1'b0);
    waitEdges(LAT + 1);
    checkOutput("simul_before", led_o, 4'h0);
    applyStimulus(4'hA, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      waitEdges(1);
      checkOutput("simul_pipe", led_o, 4'h0);
    end
    waitEdges(1);
    checkOutput("simul_after", led_o, 4'hA);

    // Exact latency of a single 0 -> 9 change.
    applyStimulus(4'h0, 1'b1);
    waitEdges(1);
    applyStimulus(4'h0, 1'b0);
    waitEdges(LAT + 1);
    checkOutput("lat_idle", led_o, 4'h0);
    applyStimulus(4'h9, 1'b0);
    for (int i = 1; i < LAT; i++) begin
      waitEdges(1);
      checkOutput("lat_early", led_o, 4'h0);
    end
    waitEdges(1);
    checkOutput("lat_exact", led_o, 4'h9);

    // Enable stuck high: register follows d every cycle.
    for (int i = 0; i < 6 + LAT - 1; i++) begin
      @(negedge clk50m_i);
      if (i < 6) key_i = stuck_vec[i];
      @(posedge clk50m_i);
      #1;
      if (i >= LAT - 1) checkOutput("stuck_en", led_o, stuck_vec[i-(LAT-1)]);
    end

    // Unknown keys during reset are absorbed.
    applyStimulus('x, 1'b1);
    waitEdges(1);
    checkOutput("x_reset", led_o, 4'h0);
    applyStimulus(4'h0, 1'b0);
    waitEdges(LAT + 1);
    checkOutput("x_after", led_o, 4'h0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dff_en_led.md
Name: dff_en_led

Overview:
- Board-level top for a 4-key / 4-LED demo of a D register with clock enable.
- Key inputs are optionally synchronized.
- The top key acts as a load enable; the remaining keys are data.
- Data is captured into an LED register only while enable is high; otherwise the LEDs hold their value.

Parameters:
- WIDTH, 4, total key/LED width; bit WIDTH-1 is enable/flag, bits WIDTH-2:0 are data (minimum 2).
- SYNC_STAGES, 2, flip-flop depth of the key synchronizer (minimum 2); used only when KEY_SYNC_EN is defined.

Ports:
- clk50m_i  input  1  50 MHz system clock; all logic on its rising edge.
- rst_i  input  1  synchronous reset, active-high.
- key_i  input  WIDTH  raw key levels, active-high (1 = pressed); asynchronous to clk50m_i on the board.
- led_o  output  WIDTH  LED drive, active-high, registered.

Behaviour:
- Single clock domain; no latches; all outputs come directly from flops.
- Reset: while rst_i=1 at a rising edge, the following clear to 0 on that edge:
  - data register
  - loaded flag
  - all synchronizer stages
- led_o=0 from the first edge with rst_i=1 onward. Reset has priority over enable.
- Define en = conditioned key bit WIDTH-1 and d = conditioned key bits WIDTH-2:0.
  - "Conditioned" means the synchronizer output with KEY_SYNC_EN, raw key_i without it.
- Data register q (WIDTH-1 bits):
  - If en=1 at an edge, q <= d.
  - If en=0, q holds.
  - Enable gates the load; the clock is never gated.
- Loaded flag: set to 1 on the first edge where en=1 after reset; stays 1 until the next reset.
- Output mapping: led_o[WIDTH-2:0] = q; led_o[WIDTH-1] = loaded flag.
- Latency, key_i change to led_o change:
  - Without KEY_SYNC_EN: 1 rising edge.
  - With KEY_SYNC_EN: SYNC_STAGES+1 rising edges.
- Simultaneous change of en and d in the same cycle: both are sampled on the same edge. If the new en=1, the new d is loaded.
- Enable stuck high: register follows d every cycle (transparent-registered).
- Reset deasserted mid-sequence: on the first edge with rst_i=0, normal sampling resumes.
  - With KEY_SYNC_EN, the pipeline is refilled from zero, so the first load appears SYNC_STAGES+1 edges after deassertion.
- X on key_i during reset is absorbed: reset overrides it.

Optional Feature:
- Macro: DFF_EN_LED_KEY_SYNC_EN.
- Defined: each key_i bit passes through an independent SYNC_STAGES-deep flop chain (reset to 0) before use.
- Not defined: key_i feeds en/d directly (bench/simulation use; inputs assumed synchronous).

Decomposition:
- Package dff_en_led_pkg holds:
  - WIDTH and SYNC_STAGES defaults.
  - The enable bit index constant (WIDTH-1).
  - The reset value constant (all zeros).
- One natural sub-module, key_sync: a parameterized-width, parameterized-depth synchronizer with synchronous active-high reset.
  - Instantiated only under DFF_EN_LED_KEY_SYNC_EN.

Test Plan:
- Reset: rst_i=1 for 1 cycle with key_i=4'hF -> led_o=4'h0 after the edge. Then rst_i=0 -> led_o=4'hF after latency (q=7, flag=1).
- Enable load sweep: key_i=15,14,13,12,11,10,9,8, one per cycle (en=1) -> led_o = 4'hF,4'hE,4'hD,4'hC,4'hB,4'hA,4'h9,4'h8, each after latency.
- Hold: after key_i=8 (q=0), apply key_i=7,6,5,...,1 (en=0) -> led_o stays 4'h8 throughout.
- Reset mid-operation: load key_i=4'hD, then rst_i=1 for 1 cycle while key_i=4'h5 -> led_o=4'h0. Stays 0 with en=0 afterwards (flag not set).
- Simultaneous change: key_i from 4'h1 to 4'hA in one cycle, starting from reset state -> led_o=4'hA after latency. No intermediate load of d=1.
- Latency check, with and without the macro: single key_i change 4'h0 to 4'h9 -> led_o=4'h9 exactly 1 edge later (off) or SYNC_STAGES+1 = 3 edges later (on).
